// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared types and constants for the target transmit path
package controller_pkg;

   typedef enum logic [1:0] {
      Idle   = 2'd0,
      Stream = 2'd1,
      Drain  = 2'd2
   } tx_arb_state_e;

   // Requester slots on the transmit arbiter, highest priority first
   localparam int unsigned TxReqCcc = 0;
   localparam int unsigned TxReqIbi = 1;
   localparam int unsigned TxReqTti = 2;

endpackage

// File: rtl/byte_skid_reg.sv
// rtl/byte_skid_reg.sv - single-entry valid/ready register holding {byte, last}
module byte_skid_reg #(
   parameter int unsigned DataWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 in_valid_i,
   input  logic [DataWidth-1:0] in_data_i,
   input  logic                 in_last_i,
   output logic                 in_ready_o,
   output logic                 out_valid_o,
   output logic [DataWidth-1:0] out_data_o,
   output logic                 out_last_o,
   input  logic                 out_ready_i
);

   logic                 r_valid;
   logic [DataWidth-1:0] r_data;
   logic                 r_last;

   assign in_ready_o  = !r_valid || out_ready_i;
   assign out_valid_o = r_valid;
   assign out_data_o  = r_data;
   assign out_last_o  = r_last;

   // Clear wins over a simultaneous load so an aborted byte never reaches the bus
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (clear_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (in_valid_i && in_ready_o) begin
         r_valid <= 1'b1;
         r_data  <= in_data_i;
         r_last  <= in_last_i;
      end else if (out_ready_i) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/tx_byte_arbiter.sv
// rtl/tx_byte_arbiter.sv - fixed-priority arbiter sharing the bus transmit byte channel
module tx_byte_arbiter
   import controller_pkg::*;
#(
   parameter  int unsigned NumReq    = 3,
   parameter  int unsigned DataWidth = 8,
   parameter  int unsigned CntWidth  = 16,
   localparam int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   input  logic                        transfer_stop_i,
   input  logic [NumReq-1:0]           req_valid_i,
   input  logic [NumReq*DataWidth-1:0] req_data_i,
   input  logic [NumReq-1:0]           req_last_i,
   output logic [NumReq-1:0]           req_ready_o,
   output logic                        tx_byte_valid_o,
   output logic [DataWidth-1:0]        tx_byte_o,
   output logic                        tx_byte_last_o,
   input  logic                        tx_byte_ready_i,
   output logic [NumReq-1:0]           grant_o,
   output logic                        busy_o,
   output logic [CntWidth-1:0]         byte_count_o,
   output logic                        abort_o,
   output logic [IdxWidth-1:0]         abort_id_o
);

   tx_arb_state_e        r_state, w_state_nxt;
   logic [NumReq-1:0]    r_grant, w_grant_nxt;
   logic [IdxWidth-1:0]  r_grant_idx, w_grant_idx_nxt;
   logic [CntWidth-1:0]  r_count;
   logic                 r_abort, w_abort_nxt;
   logic [IdxWidth-1:0]  r_abort_id;
   logic                 r_stop_pend, w_stop_pend_nxt;
   logic                 w_clear_cnt;
   logic                 w_req_any;
   logic [IdxWidth-1:0]  w_req_idx;
   logic                 w_sel_valid, w_sel_last;
   logic [DataWidth-1:0] w_sel_data;
   logic                 w_skid_ready, w_push, w_stop, w_tx_hs;

   always_comb begin
      w_req_any = |req_valid_i;
      w_req_idx = '0;
      for (int i = NumReq - 1; i >= 0; i--) begin
         if (req_valid_i[i]) w_req_idx = IdxWidth'(i);
      end
   end

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_data  = '0;
      w_sel_last  = 1'b0;
      for (int i = 0; i < NumReq; i++) begin
         if (r_grant[i]) begin
            w_sel_valid = req_valid_i[i];
            w_sel_data  = req_data_i[i*DataWidth +: DataWidth];
            w_sel_last  = req_last_i[i];
         end
      end
   end

   // A stop seen during arbitration is held over and applied once the grant is live
   assign w_stop      = (r_state != Idle) && (transfer_stop_i || r_stop_pend);
   assign w_push      = (r_state == Stream) && w_sel_valid && w_skid_ready;
   assign w_tx_hs     = tx_byte_valid_o && tx_byte_ready_i;
   assign req_ready_o = ((r_state == Stream) && w_skid_ready) ? r_grant : '0;

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_nxt     = r_grant;
      w_grant_idx_nxt = r_grant_idx;
      w_abort_nxt     = 1'b0;
      w_stop_pend_nxt = 1'b0;
      w_clear_cnt     = 1'b0;
      unique case (r_state)
         Idle: begin
            if (enable_i && w_req_any) begin
               w_state_nxt     = Stream;
               w_grant_nxt     = NumReq'(1) << w_req_idx;
               w_grant_idx_nxt = w_req_idx;
               w_clear_cnt     = 1'b1;
               w_stop_pend_nxt = transfer_stop_i;
            end
         end
         Stream: begin
            if (w_stop) begin
               w_state_nxt = Idle;
               w_grant_nxt = '0;
               w_abort_nxt = 1'b1;
            end else if (w_push && w_sel_last) begin
               w_state_nxt = Drain;
            end
         end
         Drain: begin
            if (w_stop) begin
               w_state_nxt = Idle;
               w_grant_nxt = '0;
               w_abort_nxt = 1'b1;
            end else if (w_tx_hs) begin
               w_state_nxt = Idle;
               w_grant_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = Idle;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= Idle;
         r_grant     <= '0;
         r_grant_idx <= '0;
         r_count     <= '0;
         r_abort     <= 1'b0;
         r_abort_id  <= '0;
         r_stop_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_grant_idx <= w_grant_idx_nxt;
         r_abort     <= w_abort_nxt;
         r_abort_id  <= w_abort_nxt ? r_grant_idx : '0;
         r_stop_pend <= w_stop_pend_nxt;
         if (w_clear_cnt) begin
            r_count <= '0;
         end else if (w_tx_hs && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   byte_skid_reg #(
      .DataWidth (DataWidth)
   ) u_out_reg (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (w_stop),
      .in_valid_i  (w_push),
      .in_data_i   (w_sel_data),
      .in_last_i   (w_sel_last),
      .in_ready_o  (w_skid_ready),
      .out_valid_o (tx_byte_valid_o),
      .out_data_o  (tx_byte_o),
      .out_last_o  (tx_byte_last_o),
      .out_ready_i (tx_byte_ready_i)
   );

   assign grant_o      = r_grant;
   assign busy_o       = (r_state != Idle);
   assign byte_count_o = r_count;
   assign abort_o      = r_abort;
   assign abort_id_o   = r_abort_id;

   a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_grant));

endmodule

// File: tb/tb_tx_byte_arbiter.sv
// tb/tb_tx_byte_arbiter.sv - scoreboard bench for tx_byte_arbiter
module tb_tx_byte_arbiter;
   import controller_pkg::*;

   localparam int NR = 3;
   localparam int DW = 8;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            enable_i = 1'b0;
   logic            transfer_stop_i = 1'b0;
   logic [NR-1:0]   req_valid_i = '0;
   logic [NR*DW-1:0] req_data_i = '0;
   logic [NR-1:0]   req_last_i = '0;
   logic            tx_byte_ready_i = 1'b0;

   logic [NR-1:0]   req_ready_o, grant_o;
   logic            tx_byte_valid_o, tx_byte_last_o, busy_o, abort_o;
   logic [DW-1:0]   tx_byte_o;
   logic [15:0]     byte_count_o;
   logic [1:0]      abort_id_o;

   logic [NR-1:0]   req_ready4, grant4;
   logic            tx_valid4, tx_last4, busy4, abort4;
   logic [DW-1:0]   tx_byte4;
   logic [3:0]      count4;
   logic [1:0]      abort_id4;

   tx_byte_arbiter #(.NumReq(NR), .DataWidth(DW), .CntWidth(16)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .transfer_stop_i(transfer_stop_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
      .req_ready_o(req_ready_o), .tx_byte_valid_o(tx_byte_valid_o), .tx_byte_o(tx_byte_o),
      .tx_byte_last_o(tx_byte_last_o), .tx_byte_ready_i(tx_byte_ready_i), .grant_o(grant_o),
      .busy_o(busy_o), .byte_count_o(byte_count_o), .abort_o(abort_o), .abort_id_o(abort_id_o)
   );

   tx_byte_arbiter #(.NumReq(NR), .DataWidth(DW), .CntWidth(4)) u_dut4 (
      .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .transfer_stop_i(transfer_stop_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
      .req_ready_o(req_ready4), .tx_byte_valid_o(tx_valid4), .tx_byte_o(tx_byte4),
      .tx_byte_last_o(tx_last4), .tx_byte_ready_i(tx_byte_ready_i), .grant_o(grant4),
      .busy_o(busy4), .byte_count_o(count4), .abort_o(abort4), .abort_id_o(abort_id4)
   );

   always #5 clk_i = ~clk_i;

   logic [7:0] s_data [NR][32];
   int         s_len [NR];
   int         s_idx [NR];
   logic [8:0] exp_q [$];
   int         n_vec = 0;
   int         n_err = 0;
   int         n_hs  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive_src();
      for (int i = 0; i < NR; i++) begin
         req_valid_i[i]          = (s_idx[i] < s_len[i]);
         req_data_i[i*DW +: DW]  = (s_idx[i] < s_len[i]) ? s_data[i][s_idx[i]] : 8'h00;
         req_last_i[i]           = (s_idx[i] == s_len[i] - 1);
      end
   endtask

   task automatic load_src(input int i, input logic [7:0] first, input int n);
      for (int k = 0; k < n; k++) s_data[i][k] = first + 8'(k);
      s_len[i] = n;
      s_idx[i] = 0;
   endtask

   task automatic flush_src();
      for (int i = 0; i < NR; i++) s_len[i] = s_idx[i];
      drive_src();
   endtask

   // Sample handshakes mid-cycle, then advance producers just after the edge
   task automatic tick();
      logic [NR-1:0] acc;
      logic [8:0]    exp;
      @(negedge clk_i);
      acc = req_valid_i & req_ready_o;
      if (tx_byte_valid_o && tx_byte_ready_i) begin
         n_hs++;
         check_eq("tx_expected_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check_eq("tx_byte", {23'd0, tx_byte_last_o, tx_byte_o}, {23'd0, exp});
         end
      end
      if (transfer_stop_i && busy_o) begin
         exp_q.delete();
      end else begin
         for (int i = 0; i < NR; i++)
            if (acc[i]) exp_q.push_back({req_last_i[i], req_data_i[i*DW +: DW]});
      end
      @(posedge clk_i);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) s_idx[i]++;
      drive_src();
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      while (busy_o && k < bound) begin
         tick();
         k++;
      end
      check_eq("idle_timeout", 32'(busy_o), 32'd0);
   endtask

   initial begin
      logic [3:0] pat;
      logic       stalled;
      logic [8:0] held;
      int         k;
      for (int i = 0; i < NR; i++) begin s_len[i] = 0; s_idx[i] = 0; end
      tick();
      tick();
      check_eq("rst_grant", 32'(grant_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_tx_valid", 32'(tx_byte_valid_o), 32'd0);
      check_eq("rst_count", 32'(byte_count_o), 32'd0);
      check_eq("rst_abort", 32'(abort_o), 32'd0);
      check_eq("rst_ready", 32'(req_ready_o), 32'd0);
      rst_ni = 1'b1;

      // TTI alone
      enable_i = 1'b1;
      tx_byte_ready_i = 1'b1;
      load_src(TxReqTti, 8'hA1, 3);
      drive_src();
      check_eq("t1_arb_ready", 32'(req_ready_o), 32'd0);
      check_eq("t1_arb_grant", 32'(grant_o), 32'd0);
      tick();
      check_eq("t1_grant", 32'(grant_o), 32'b100);
      check_eq("t1_busy", 32'(busy_o), 32'd1);
      check_eq("t1_ready", 32'(req_ready_o), 32'b100);
      check_eq("t1_no_tx_yet", 32'(tx_byte_valid_o), 32'd0);
      tick();
      check_eq("t1_first_valid", 32'(tx_byte_valid_o), 32'd1);
      check_eq("t1_first_byte", 32'(tx_byte_o), 32'hA1);
      wait_idle(20);
      check_eq("t1_count", 32'(byte_count_o), 32'd3);
      check_eq("t1_grant_idle", 32'(grant_o), 32'd0);
      check_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);

      // CCC and IBI together
      load_src(TxReqCcc, 8'hC0, 3);
      load_src(TxReqIbi, 8'hB0, 2);
      drive_src();
      tick();
      check_eq("t2_ccc_grant", 32'(grant_o), 32'b001);
      k = 0;
      while (grant_o == 3'b001 && k < 20) begin
         check_eq("t2_ibi_wait", 32'(req_ready_o[1]), 32'd0);
         tick();
         k++;
      end
      check_eq("t2_idle_between", 32'(grant_o), 32'd0);
      check_eq("t2_busy_between", 32'(busy_o), 32'd0);
      tick();
      check_eq("t2_ibi_grant", 32'(grant_o), 32'b010);
      wait_idle(20);
      check_eq("t2_count", 32'(byte_count_o), 32'd2);
      check_eq("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure 1,0,0,1
      pat = 4'b1001;
      load_src(TxReqCcc, 8'h10, 4);
      drive_src();
      tick();
      stalled = 1'b0;
      held = '0;
      k = 0;
      while (busy_o && k < 30) begin
         if (stalled && tx_byte_valid_o)
            check_eq("t3_stable", {23'd0, tx_byte_last_o, tx_byte_o}, {23'd0, held});
         tx_byte_ready_i = pat[k % 4];
         stalled = tx_byte_valid_o && !tx_byte_ready_i;
         held = {tx_byte_last_o, tx_byte_o};
         tick();
         k++;
      end
      check_eq("t3_idle", 32'(busy_o), 32'd0);
      check_eq("t3_count", 32'(byte_count_o), 32'd4);
      check_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // Stop after two IBI bytes delivered
      tx_byte_ready_i = 1'b1;
      load_src(TxReqIbi, 8'h40, 5);
      drive_src();
      tick();
      n_hs = 0;
      k = 0;
      while (n_hs < 2 && k < 20) begin tick(); k++; end
      tx_byte_ready_i = 1'b0;
      transfer_stop_i = 1'b1;
      tick();
      transfer_stop_i = 1'b0;
      flush_src();
      check_eq("t4_tx_valid", 32'(tx_byte_valid_o), 32'd0);
      check_eq("t4_grant", 32'(grant_o), 32'd0);
      check_eq("t4_abort", 32'(abort_o), 32'd1);
      check_eq("t4_abort_id", 32'(abort_id_o), 32'd1);
      check_eq("t4_count", 32'(byte_count_o), 32'd2);
      check_eq("t4_busy", 32'(busy_o), 32'd0);
      tx_byte_ready_i = 1'b1;
      tick();
      check_eq("t4_abort_pulse", 32'(abort_o), 32'd0);

      // Stop coincident with last-byte acceptance
      load_src(TxReqCcc, 8'h55, 2);
      drive_src();
      tick();
      k = 0;
      while (!(req_ready_o[0] && req_last_i[0]) && k < 10) begin tick(); k++; end
      check_eq("t5_reach_last", 32'(req_ready_o[0] & req_last_i[0]), 32'd1);
      transfer_stop_i = 1'b1;
      tick();
      transfer_stop_i = 1'b0;
      flush_src();
      check_eq("t5_abort", 32'(abort_o), 32'd1);
      check_eq("t5_abort_id", 32'(abort_id_o), 32'd0);
      check_eq("t5_grant", 32'(grant_o), 32'd0);
      check_eq("t5_tx_valid", 32'(tx_byte_valid_o), 32'd0);
      check_eq("t5_count", 32'(byte_count_o), 32'd1);
      tick();
      tick();
      check_eq("t5_last_never_sent", 32'(tx_byte_valid_o), 32'd0);
      check_eq("t5_sb_empty", 32'(exp_q.size()), 32'd0);
      transfer_stop_i = 1'b1;
      tick();
      transfer_stop_i = 1'b0;
      check_eq("t5_idle_stop_abort", 32'(abort_o), 32'd0);
      check_eq("t5_idle_stop_busy", 32'(busy_o), 32'd0);

      // Enable gating
      enable_i = 1'b0;
      load_src(TxReqTti, 8'hE0, 2);
      drive_src();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t6_no_grant", 32'(grant_o), 32'd0);
      end
      enable_i = 1'b1;
      tick();
      check_eq("t6_grant", 32'(grant_o), 32'b100);
      wait_idle(20);
      check_eq("t6_count", 32'(byte_count_o), 32'd2);

      // Counter saturation on the narrow-counter instance
      load_src(TxReqCcc, 8'h80, 20);
      drive_src();
      tick();
      wait_idle(60);
      check_eq("t7_count_sat", 32'(count4), 32'd15);
      check_eq("t7_count_wide", 32'(byte_count_o), 32'd20);
      check_eq("t7_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
